efb_i2c_ctl: RTL and testbench
==============================

# efb_i2c_ctl

Sequencer between the MachXO2 EFB hard I2C slave (reached over its WISHBONE port) and the flasher's 6-bit register file. It initialises the EFB I2C core, polls its status register, pulls received bytes from RXDR, decodes the tagged address/data byte protocol into register write and read strobes, and feeds read-back data into TXDR. It is the only WISHBONE master on the EFB and sits between the `EFB` primitive and the LED/control registers inside `flasher`.

## Interface
Parameters:
- `I2C_BASE`, 8'h40: EFB address of I2C1_CR. CMDR=+1, TXDR=+4, SR=+5, RXDR=+7.
- `POLL_GAP`, 4: idle clocks between consecutive SR polls (≥1).
- `ACK_TIMEOUT`, 16: clocks to wait for `wb_ack_i` before aborting an access.

Ports:
- `CLK`  in  1: system clock. One clock domain.
- `GSRn`  in  1: reset. Asynchronous, active-low.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each: WISHBONE master controls.
- `wb_adr_o`  out  8: EFB register address.
- `wb_dat_o`  out  8: write data.
- `wb_dat_i`  in  8: read data.
- `wb_ack_i`  in  1: access acknowledge.
- `reg_addr`  out  `I2C_DATA_BITS` (6): current register pointer.
- `reg_wdata`  out  6: write data, valid with `reg_wr`.
- `reg_wr`  out  1: one-clock register write strobe.
- `reg_rd`  out  1: one-clock register read strobe.
- `reg_rdata`  in  6: read data; sampled on the clock after `reg_rd`.
- `wb_err`  out  1: one-clock pulse on an ACK timeout or an illegal tag.

## Operation
- Byte format: bits [7:6] are the tag, bits [5:0] are the payload. `A_ADDR`=2'b00, `D_ADDR`=2'b01. Tags 2'b10 and 2'b11 are illegal.
- Reset: all outputs 0 and `reg_addr`=0. Reset asserted mid-access drops `cyc`/`stb` immediately and the FSM returns to INIT.
- FSM states: INIT → POLL → (RX | FETCH | GAP) → … .
  - INIT: write CR=8'h80 (core enable). Then go to GAP.
  - GAP: count `POLL_GAP` clocks, then go to POLL.
  - POLL: read SR. SR bits: 7 TIP, 6 BUSY, 4 SRW, 2 TRRDY.
    - BUSY=1, TRRDY=1, SRW=0 → RX.
    - BUSY=1, TRRDY=1, SRW=1 → FETCH.
    - Anything else → GAP.
  - RX: read RXDR, then go to DECODE.
    - `A_ADDR` tag: load `reg_addr` with the payload.
    - `D_ADDR` tag: pulse `reg_wr` with `reg_wdata`=payload, then increment `reg_addr` one clock later.
    - Illegal tag: pulse `wb_err`, byte dropped.
    - Then go to GAP.
  - FETCH: pulse `reg_rd`, capture `reg_rdata` on the next clock, write TXDR = {`D_ADDR`, rdata}, increment `reg_addr`, go to GAP.
- `reg_addr` increment wraps 63 → 0.
- `reg_wr` and `reg_rd` are never asserted together and never during a WISHBONE access.

## Timing
- WISHBONE access: `cyc`, `stb`, `adr`, `we` and `dat_o` are asserted together and held stable until `wb_ack_i` is sampled high.
  - All five deassert on the next clock.
  - At least one idle clock follows every access, as the EFB requires.
- Timeout: no ack within `ACK_TIMEOUT` clocks of `stb` rising → drop `cyc`/`stb`, pulse `wb_err`, go to GAP. The failed access is not retried. From INIT, the CR write is retried after the GAP.
- RXDR ack at clock N → `reg_wr` or `reg_addr` update at N+1. The `reg_addr` increment after a `D_ADDR` write is at N+2.
- SR ack at clock N (read condition) → `reg_rd` at N+1, `reg_rdata` captured at N+2, TXDR `stb` at N+3.
- SR poll period with zero-wait ack: 1 (stb) + 1 (idle) + `POLL_GAP` clocks.

## Structure
- Package `pifdefs`: `I2C_DATA_BITS`=6, `A_ADDR`, `D_ADDR`, the EFB I2C register offsets and the SR bit indices.
- Sub-module `efb_wb_xfer`: single-access WISHBONE engine with timeout.
  - Inputs: `start`, `we`, `adr`, `wdat`.
  - Outputs: `done`, `rdat`, `timeout`.
  - The top FSM issues one access at a time through it.

## Test plan
- Reset release with a zero-wait WISHBONE slave model:
  - First access is a write of 8'h80 to 8'h40.
  - Next access is a read of 8'h45 after exactly `POLL_GAP`+1 idle clocks.
- SR=8'h44 with RXDR returning 8'h02, then SR=8'h44 with RXDR 8'h41:
  - `reg_addr`=2.
  - `reg_wr` pulses once with `reg_wdata`=1 at `reg_addr`=2.
  - `reg_addr` then becomes 3.
- `reg_addr`=63, then a `D_ADDR` byte 8'h7F:
  - Write of 6'h3F at address 63.
  - `reg_addr` wraps to 0.
- SR=8'h54 with `reg_rdata`=6'h15:
  - `reg_rd` pulse.
  - TXDR (8'h44) written with 8'h55.
  - `reg_addr` increments.
- Slave never acks the SR read: `stb` drops after 16 clocks, `wb_err` pulses once, and polling resumes.
- RXDR=8'hC3, then `GSRn` low during a pending access:
  - 8'hC3 pulses `wb_err` with no `reg_wr`.
  - The reset zeroes `cyc`/`stb` asynchronously, and the CR write is reissued after reset release.

Source files
------------

// File: rtl/efb_i2c_ctl_pkg.sv
// Shared definitions for the EFB I2C sequencer: byte tags, EFB I2C register
// offsets, status-register bit positions and the top-level FSM states.
package pifdefs;

   localparam int I2C_DATA_BITS = 6;

   localparam logic [1:0] A_ADDR = 2'b00;
   localparam logic [1:0] D_ADDR = 2'b01;

   localparam logic [7:0] OFS_CR   = 8'd0;
   localparam logic [7:0] OFS_CMDR = 8'd1;
   localparam logic [7:0] OFS_TXDR = 8'd4;
   localparam logic [7:0] OFS_SR   = 8'd5;
   localparam logic [7:0] OFS_RXDR = 8'd7;

   localparam int SR_TIP   = 7;
   localparam int SR_BUSY  = 6;
   localparam int SR_SRW   = 4;
   localparam int SR_TRRDY = 2;

   localparam logic [7:0] CR_EN = 8'h80;

   typedef enum logic [3:0] {
      S_INIT,
      S_INIT_W,
      S_GAP,
      S_POLL_W,
      S_RX_W,
      S_INC,
      S_RD,
      S_TXC,
      S_TX_W
   } ctl_state_e;

endpackage

// File: rtl/efb_i2c_ctl_wb_xfer.sv
// Single-access WISHBONE master engine: latches a request on start, holds the
// bus until ack, and gives up after ACK_TIMEOUT clocks without one.
module efb_wb_xfer #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       we,
   input  logic [7:0] adr,
   input  logic [7:0] wdat,
   output logic       done,
   output logic [7:0] rdat,
   output logic       timeout,
   output logic       wb_cyc_o,
   output logic       wb_stb_o,
   output logic       wb_we_o,
   output logic [7:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   input  logic       wb_ack_i,
   input  logic [7:0] wb_dat_i
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   logic          r_stb;
   logic          r_we;
   logic [7:0]    r_adr;
   logic [7:0]    r_dat;
   logic [CW-1:0] r_cnt;
   logic          w_end;

   // done/timeout are combinational so the caller can act on the ack edge itself
   assign done    = r_stb & wb_ack_i;
   assign timeout = r_stb & ~wb_ack_i & (r_cnt == CNT_LAST);
   assign w_end   = done | timeout;
   assign rdat    = wb_dat_i;

   assign wb_cyc_o = r_stb;
   assign wb_stb_o = r_stb;
   assign wb_we_o  = r_we;
   assign wb_adr_o = r_adr;
   assign wb_dat_o = r_dat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stb <= 1'b0;
         r_we  <= 1'b0;
         r_adr <= 8'h00;
         r_dat <= 8'h00;
         r_cnt <= '0;
      end else if (r_stb) begin
         if (w_end) begin
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= 8'h00;
            r_dat <= 8'h00;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else if (start) begin
         r_stb <= 1'b1;
         r_we  <= we;
         r_adr <= adr;
         r_dat <= wdat;
         r_cnt <= '0;
      end
   end

endmodule

// File: rtl/efb_i2c_ctl.sv
// Sequencer between the EFB hard I2C slave and the 6-bit register file:
// initialises the core, polls SR, decodes tagged RX bytes and answers reads.
module efb_i2c_ctl
   import pifdefs::*;
#(
   parameter logic [7:0] I2C_BASE    = 8'h40,
   parameter int         POLL_GAP    = 4,
   parameter int         ACK_TIMEOUT = 16
) (
   input  logic                     CLK,
   input  logic                     GSRn,
   output logic                     wb_cyc_o,
   output logic                     wb_stb_o,
   output logic                     wb_we_o,
   output logic [7:0]               wb_adr_o,
   output logic [7:0]               wb_dat_o,
   input  logic [7:0]               wb_dat_i,
   input  logic                     wb_ack_i,
   output logic [I2C_DATA_BITS-1:0] reg_addr,
   output logic [5:0]               reg_wdata,
   output logic                     reg_wr,
   output logic                     reg_rd,
   input  logic [5:0]               reg_rdata,
   output logic                     wb_err
);

   localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

   ctl_state_e               r_state;
   logic                     r_start;
   logic                     r_we;
   logic [7:0]               r_adr;
   logic [7:0]               r_gap;
   logic                     r_inited;
   logic [I2C_DATA_BITS-1:0] r_addr;
   logic [5:0]               r_wdata;
   logic                     r_wr;
   logic                     r_rd;
   logic                     r_err;

   logic       w_done;
   logic       w_timeout;
   logic [7:0] w_rdat;
   logic [7:0] w_wdat;
   logic       w_ready;

   // read-back data goes straight from the register file into the TXDR request
   assign w_wdat  = (r_state == S_TXC) ? {D_ADDR, reg_rdata} : CR_EN;
   assign w_ready = w_rdat[SR_BUSY] & w_rdat[SR_TRRDY];

   assign reg_addr  = r_addr;
   assign reg_wdata = r_wdata;
   assign reg_wr    = r_wr;
   assign reg_rd    = r_rd;
   assign wb_err    = r_err;

   efb_wb_xfer #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_xfer (
      .clk      (CLK),
      .rst_n    (GSRn),
      .start    (r_start),
      .we       (r_we),
      .adr      (r_adr),
      .wdat     (w_wdat),
      .done     (w_done),
      .rdat     (w_rdat),
      .timeout  (w_timeout),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_we_o  (wb_we_o),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_ack_i (wb_ack_i),
      .wb_dat_i (wb_dat_i)
   );

   always_ff @(posedge CLK or negedge GSRn) begin
      if (!GSRn) begin
         r_state  <= S_INIT;
         r_start  <= 1'b0;
         r_we     <= 1'b0;
         r_adr    <= 8'h00;
         r_gap    <= 8'h00;
         r_inited <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= 6'h00;
         r_wr     <= 1'b0;
         r_rd     <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_wr    <= 1'b0;
         r_rd    <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            S_INIT: begin
               r_start <= 1'b1;
               r_we    <= 1'b1;
               r_adr   <= I2C_BASE + OFS_CR;
               r_state <= S_INIT_W;
            end
            S_GAP: begin
               if (r_gap == GAP_LAST) begin
                  r_start <= 1'b1;
                  // a failed CR write is reissued instead of polling
                  if (r_inited) begin
                     r_we    <= 1'b0;
                     r_adr   <= I2C_BASE + OFS_SR;
                     r_state <= S_POLL_W;
                  end else begin
                     r_we    <= 1'b1;
                     r_adr   <= I2C_BASE + OFS_CR;
                     r_state <= S_INIT_W;
                  end
               end else begin
                  r_gap <= r_gap + 8'd1;
               end
            end
            S_INIT_W: begin
               if (w_done || w_timeout) begin
                  r_inited <= w_done;
                  r_err    <= w_timeout;
                  r_gap    <= 8'h00;
                  r_state  <= S_GAP;
               end
            end
            S_POLL_W: begin
               if (w_done && w_ready && !w_rdat[SR_SRW]) begin
                  r_start <= 1'b1;
                  r_we    <= 1'b0;
                  r_adr   <= I2C_BASE + OFS_RXDR;
                  r_state <= S_RX_W;
               end else if (w_done && w_ready) begin
                  r_rd    <= 1'b1;
                  r_state <= S_RD;
               end else if (w_done || w_timeout) begin
                  r_err   <= w_timeout;
                  r_gap   <= 8'h00;
                  r_state <= S_GAP;
               end
            end
            S_RX_W: begin
               if (w_done) begin
                  r_gap   <= 8'h00;
                  r_state <= S_GAP;
                  case (w_rdat[7:6])
                     A_ADDR: r_addr <= w_rdat[5:0];
                     D_ADDR: begin
                        r_wr    <= 1'b1;
                        r_wdata <= w_rdat[5:0];
                        r_state <= S_INC;
                     end
                     default: r_err <= 1'b1;
                  endcase
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_gap   <= 8'h00;
                  r_state <= S_GAP;
               end
            end
            S_INC: begin
               r_addr  <= r_addr + 1'b1;
               r_gap   <= 8'h00;
               r_state <= S_GAP;
            end
            S_RD: begin
               r_start <= 1'b1;
               r_we    <= 1'b1;
               r_adr   <= I2C_BASE + OFS_TXDR;
               r_state <= S_TXC;
            end
            S_TXC: begin
               r_addr  <= r_addr + 1'b1;
               r_state <= S_TX_W;
            end
            S_TX_W: begin
               if (w_done || w_timeout) begin
                  r_err   <= w_timeout;
                  r_gap   <= 8'h00;
                  r_state <= S_GAP;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_efb_i2c_ctl.sv
// Randomised bench for efb_i2c_ctl: a zero-wait EFB slave model feeds SR/RXDR
// values and a transaction-level model predicts register-file activity.
module tb_efb_i2c_ctl;

   localparam int POLL_GAP    = 4;
   localparam int ACK_TIMEOUT = 16;

   logic       CLK = 1'b0;
   logic       GSRn = 1'b0;
   logic       wb_cyc_o, wb_stb_o, wb_we_o;
   logic [7:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic       wb_ack_i;
   logic [5:0] reg_addr, reg_wdata;
   logic       reg_wr, reg_rd, wb_err;
   logic [5:0] reg_rdata = 6'h00;

   logic [7:0] sr_val = 8'h00;
   logic [7:0] rx_val = 8'h00;
   logic       ack_en = 1'b1;

   typedef struct {int t; logic we; logic [7:0] adr; logic [7:0] dat;} acc_t;
   typedef struct {int t; logic [5:0] a; logic [5:0] d;} ev_t;

   acc_t       acc_q[$];
   ev_t        wr_q[$];
   ev_t        rd_q[$];
   logic [5:0] addr_hist[$];
   int         err_cnt = 0;
   logic       prev_sr_ack = 1'b0;
   int         n_chk = 0;
   int         n_pass = 0;
   logic [5:0] m_addr = 6'd0;

   always #5 CLK = ~CLK;

   assign wb_ack_i = wb_stb_o & ack_en;
   assign wb_dat_i = (wb_adr_o == 8'h45) ? sr_val :
                     (wb_adr_o == 8'h47) ? rx_val : 8'h00;

   efb_i2c_ctl #(
      .I2C_BASE    (8'h40),
      .POLL_GAP    (POLL_GAP),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .CLK       (CLK),
      .GSRn      (GSRn),
      .wb_cyc_o  (wb_cyc_o),
      .wb_stb_o  (wb_stb_o),
      .wb_we_o   (wb_we_o),
      .wb_adr_o  (wb_adr_o),
      .wb_dat_o  (wb_dat_o),
      .wb_dat_i  (wb_dat_i),
      .wb_ack_i  (wb_ack_i),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_wr    (reg_wr),
      .reg_rd    (reg_rd),
      .reg_rdata (reg_rdata),
      .wb_err    (wb_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock: sample at the falling edge, log bus accesses and strobes.
   task automatic tick();
      int t;
      @(negedge CLK);
      if (prev_sr_ack) sr_val = 8'h00;
      t = addr_hist.size();
      addr_hist.push_back(reg_addr);
      if (wb_stb_o && wb_ack_i) acc_q.push_back('{t, wb_we_o, wb_adr_o, wb_dat_o});
      if (reg_wr) wr_q.push_back('{t, reg_addr, reg_wdata});
      if (reg_rd) rd_q.push_back('{t, reg_addr, 6'h00});
      if (reg_wr && reg_rd) chk("wr_rd_overlap", 1, 0);
      if ((reg_wr || reg_rd) && wb_cyc_o) chk("strobe_in_access", 1, 0);
      if (wb_err) err_cnt++;
      prev_sr_ack = wb_stb_o && wb_ack_i && !wb_we_o && (wb_adr_o == 8'h45);
   endtask

   task automatic wait_idle();
      int g = 0;
      while ((wb_cyc_o || prev_sr_ack) && g < 100) begin tick(); g++; end
   endtask

   // Present one SR value (plus RXDR byte / read-back data) and compare the
   // controller's reaction, up to the following idle poll, with the model.
   task automatic txn(input logic [7:0] sr, input logic [7:0] rx, input logic [5:0] rd);
      int   g, n_sr, n_oth;
      acc_t s1, s2, oth;
      logic is_rx, is_fetch;
      wait_idle();
      acc_q.delete(); wr_q.delete(); rd_q.delete(); err_cnt = 0;
      sr_val = sr; rx_val = rx; reg_rdata = rd;
      n_sr = 0; g = 0;
      while (n_sr < 2 && g < 400) begin
         tick(); g++;
         n_sr = 0;
         foreach (acc_q[i]) if (!acc_q[i].we && acc_q[i].adr == 8'h45) n_sr++;
      end
      if (n_sr < 2) begin chk("txn_bound", n_sr, 2); return; end
      n_sr = 0; n_oth = 0;
      foreach (acc_q[i]) begin
         if (!acc_q[i].we && acc_q[i].adr == 8'h45) begin
            if (n_sr == 0) s1 = acc_q[i]; else s2 = acc_q[i];
            n_sr++;
         end else begin
            oth = acc_q[i]; n_oth++;
         end
      end
      is_rx    = sr[6] && sr[2] && !sr[4];
      is_fetch = sr[6] && sr[2] && sr[4];
      chk("acc_count", n_oth, (is_rx || is_fetch) ? 1 : 0);
      if (is_rx && n_oth == 1) begin
         chk("rx_adr", {oth.we, oth.adr}, {1'b0, 8'h47});
         if (rx[7:6] == 2'b00) begin
            chk("wr_cnt", wr_q.size(), 0);
            chk("err_cnt", err_cnt, 0);
            chk("addr_load", addr_hist[oth.t + 1], rx[5:0]);
            m_addr = rx[5:0];
         end else if (rx[7:6] == 2'b01) begin
            chk("wr_cnt", wr_q.size(), 1);
            chk("err_cnt", err_cnt, 0);
            if (wr_q.size() == 1) begin
               chk("wr_lat", wr_q[0].t - oth.t, 1);
               chk("wr_addr", wr_q[0].a, m_addr);
               chk("wr_data", wr_q[0].d, rx[5:0]);
            end
            chk("addr_hold", addr_hist[oth.t + 1], m_addr);
            m_addr = m_addr + 6'd1;
            chk("addr_inc", addr_hist[oth.t + 2], m_addr);
         end else begin
            chk("wr_cnt", wr_q.size(), 0);
            chk("err_cnt", err_cnt, 1);
         end
         chk("rd_cnt", rd_q.size(), 0);
      end else if (is_fetch && n_oth == 1) begin
         chk("rd_cnt", rd_q.size(), 1);
         if (rd_q.size() == 1) begin
            chk("rd_lat", rd_q[0].t - s1.t, 1);
            chk("rd_addr", rd_q[0].a, m_addr);
         end
         chk("tx_wr", {oth.we, oth.adr, oth.dat}, {1'b1, 8'h44, 2'b01, rd});
         chk("tx_lat", oth.t - s1.t, 3);
         chk("wr_cnt", wr_q.size(), 0);
         m_addr = m_addr + 6'd1;
      end else if (!is_rx && !is_fetch) begin
         chk("poll_period", s2.t - s1.t, POLL_GAP + 2);
         chk("wr_cnt", wr_q.size(), 0);
         chk("rd_cnt", rd_q.size(), 0);
      end
      chk("reg_addr", reg_addr, m_addr);
   endtask

   initial begin
      int         g, n;
      logic [7:0] r;
      // reset state and bring-up sequence
      repeat (3) tick();
      chk("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, 0);
      chk("rst_reg", {reg_addr, reg_wdata, reg_wr, reg_rd, wb_err}, 0);
      acc_q.delete();
      GSRn = 1'b1;
      g = 0;
      while (acc_q.size() < 2 && g < 100) begin tick(); g++; end
      if (acc_q.size() < 2) chk("boot_bound", acc_q.size(), 2);
      else begin
         chk("boot_cr", {acc_q[0].we, acc_q[0].adr, acc_q[0].dat}, {1'b1, 8'h40, 8'h80});
         chk("boot_sr", {acc_q[1].we, acc_q[1].adr}, {1'b0, 8'h45});
         chk("boot_idle", acc_q[1].t - acc_q[0].t - 1, POLL_GAP + 1);
      end

      // directed register-file transactions
      txn(8'h44, 8'h02, 6'h00);
      txn(8'h44, 8'h41, 6'h00);
      txn(8'h44, 8'h3F, 6'h00);
      txn(8'h44, 8'h7F, 6'h00);
      txn(8'h54, 8'h00, 6'h15);
      txn(8'h40, 8'h41, 6'h00);

      // randomised transactions
      for (int k = 0; k < 30; k++) begin
         r = 8'($urandom);
         case ($urandom_range(0, 2))
            0: r = (r & 8'hEB) | 8'h44;
            1: r = r | 8'h54;
            default: if (r[6] && r[2]) r[$urandom_range(0, 1) ? 6 : 2] = 1'b0;
         endcase
         txn(r, 8'($urandom), 6'($urandom));
      end

      // slave never acks an SR read
      wait_idle();
      ack_en = 1'b0;
      g = 0;
      while (!wb_stb_o && g < 50) begin tick(); g++; end
      chk("to_adr", wb_adr_o, 8'h45);
      n = 0;
      while (wb_stb_o && n < 100) begin n++; tick(); end
      chk("to_len", n, ACK_TIMEOUT);
      chk("to_err", wb_err, 1);
      tick();
      chk("to_err_pulse", wb_err, 0);
      ack_en = 1'b1;
      acc_q.delete();
      g = 0;
      while (acc_q.size() == 0 && g < 50) begin tick(); g++; end
      chk("to_resume", (acc_q.size() > 0) ? {acc_q[0].we, acc_q[0].adr} : 9'h0, {1'b0, 8'h45});

      // illegal tag, then reset during a pending access
      txn(8'h44, 8'hC3, 6'h00);
      wait_idle();
      ack_en = 1'b0;
      g = 0;
      while (!wb_stb_o && g < 50) begin tick(); g++; end
      tick(); tick();
      #2 GSRn = 1'b0;
      #1;
      chk("arst_bus", {wb_cyc_o, wb_stb_o}, 2'b00);
      chk("arst_addr", reg_addr, 0);
      m_addr = 6'd0;
      repeat (2) tick();
      GSRn = 1'b1;
      ack_en = 1'b1;
      acc_q.delete();
      g = 0;
      while (acc_q.size() == 0 && g < 50) begin tick(); g++; end
      chk("arst_cr", (acc_q.size() > 0) ? {acc_q[0].we, acc_q[0].adr, acc_q[0].dat} : 17'h0,
          {1'b1, 8'h40, 8'h80});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
